alu_issue_stage: RTL and testbench
==================================

// Module: alu_issue_stage
// PURPOSE
//   Two-stage valid/ready wrapper that issues commands to the combinational ALU and captures its results.
//   Stage 1 registers an accepted command and drives the ALU operand/select ports.
//   Stage 2 registers the returned alu_out together with status flags for the downstream consumer.
//   Provides full backpressure without bubbles and counts completed operations.
// PARAMETERS
//   DATA_WIDTH   4   operand width; the result is 2*DATA_WIDTH (matches the ALU)
//   COUNT_WIDTH  8   width of the completed-operation counter
// PORTS
//   clk_in        in   1             clock, all flops on the rising edge
//   rst_n_in      in   1             reset, asynchronous, active-low
//   cmd_valid_in  in   1             command valid
//   cmd_ready_out out  1             command accepted when valid & ready
//   cmd_op_in     in   3             opcode: 000 ADD, 001 SUB, 010 MULT, 011 AND, 100 OR, 101 XOR
//   cmd_a_in      in   DATA_WIDTH    signed operand A
//   cmd_b_in      in   DATA_WIDTH    signed operand B
//   alu_sel_out   out  3             to ALU sel_in (stage-1 register)
//   alu_a_out     out  DATA_WIDTH    to ALU a_in (stage-1 register)
//   alu_b_out     out  DATA_WIDTH    to ALU b_in (stage-1 register)
//   alu_res_in    in   2*DATA_WIDTH  from ALU alu_out (combinational return)
//   res_valid_out out  1             result valid
//   res_ready_in  in   1             downstream ready
//   res_data_out  out  2*DATA_WIDTH  signed result
//   res_zero_out  out  1             result == 0
//   res_neg_out   out  1             result MSB
//   res_ill_out   out  1             opcode was 110/111 (illegal)
//   op_count_out  out  COUNT_WIDTH   number of results handed off downstream
//   busy_out      out  1             s1_valid | s2_valid
// BEHAVIOUR
//   Reset: all registers clear asynchronously to 0, including s1_valid, s2_valid, alu_* outputs,
//     res_* outputs and op_count_out. cmd_ready_out = 1 while the rst_n_in deassertion takes effect.
//   Reset mid-operation discards in-flight commands. No result is emitted for them.
//   Definitions:
//     s2_free  = !s2_valid | res_ready_in
//     s1_adv   = s1_valid & s2_free
//     cmd_ready_out = !s1_valid | s1_adv   (combinational, no dependency on cmd_valid_in)
//   Accept (cmd_valid_in & cmd_ready_out):
//     - load op, a and b into stage 1 (alu_sel/a/b_out)
//     - set s1_valid
//     - if not accepting and s1_adv, clear s1_valid
//   Stage-1 registers hold their value whenever no accept occurs; the ALU inputs never glitch while stalled.
//   s1_adv:
//     - res_data_out <= alu_res_in
//     - zero/neg derive from alu_res_in
//     - res_ill_out <= (alu_sel_out > 3'b101); res_data_out is 0 in that case (the ALU default gives 0)
//     - set s2_valid
//   Handoff (res_valid_out & res_ready_in) with no s1_adv: clear s2_valid.
//   res_* outputs are stable while res_valid_out=1 and res_ready_in=0. The downstream AXI-style rule applies.
//   Latency: command accept at edge N gives res_valid_out high after edge N+1 (2-cycle issue-to-result).
//   Throughput: 1 op/cycle with res_ready_in held high; simultaneous accept, advance and handoff in one cycle is legal.
//   Full: both stages valid and res_ready_in=0 -> cmd_ready_out=0, all registers hold.
//   Empty: busy_out=0, res_valid_out=0. res_data_out keeps its last value (don't-care).
//   op_count_out increments on each handoff, including illegal-op results; it wraps from 2^COUNT_WIDTH-1 to 0.
//   Arithmetic is done entirely in the external ALU. This block only registers, flags and counts.
// TESTING
//   1. Single ADD a=3, b=2, res_ready=1 -> res_valid 2 cycles after accept, data=5, zero=0, neg=0, count=1.
//   2. SUB a=-8, b=7 -> data=8'hF1 (-15), neg=1. MULT a=-8, b=-8 -> data=64. XOR a=5, b=5 -> data=0, zero=1.
//   3. Stream 6 ops back-to-back, res_ready=1 -> one result per cycle in order, cmd_ready never drops.
//   4. Hold res_ready=0 after 2 accepts -> cmd_ready=0, res_data stable. Release -> both drain in order, nothing lost or duplicated.
//   5. Opcode 3'b111, a=1, b=1 -> res_ill=1, data=0, zero=1, count increments.
//   6. Assert rst_n low with both stages full -> all outputs 0 immediately. After release, no stale result appears.
//      COUNT_WIDTH=2: 5 handoffs -> count=1 (wrap).

Source files
------------

// File: rtl/alu_issue_if.sv
// Handshake and ALU-side bus of the ALU issue stage.
// The slave modport is the issue stage itself; the master modport is the surrounding system.
interface alu_issue_if #(
    parameter int DATA_WIDTH  = 4,
    parameter int COUNT_WIDTH = 8
);
    logic                      cmd_valid_in;
    logic                      cmd_ready_out;
    logic [2:0]                cmd_op_in;
    logic [DATA_WIDTH-1:0]     cmd_a_in;
    logic [DATA_WIDTH-1:0]     cmd_b_in;
    logic [2:0]                alu_sel_out;
    logic [DATA_WIDTH-1:0]     alu_a_out;
    logic [DATA_WIDTH-1:0]     alu_b_out;
    logic [2*DATA_WIDTH-1:0]   alu_res_in;
    logic                      res_valid_out;
    logic                      res_ready_in;
    logic [2*DATA_WIDTH-1:0]   res_data_out;
    logic                      res_zero_out;
    logic                      res_neg_out;
    logic                      res_ill_out;
    logic [COUNT_WIDTH-1:0]    op_count_out;
    logic                      busy_out;

    modport slave (
        input  cmd_valid_in, cmd_op_in, cmd_a_in, cmd_b_in, alu_res_in, res_ready_in,
        output cmd_ready_out, alu_sel_out, alu_a_out, alu_b_out,
        output res_valid_out, res_data_out, res_zero_out, res_neg_out, res_ill_out,
        output op_count_out, busy_out
    );

    modport master (
        output cmd_valid_in, cmd_op_in, cmd_a_in, cmd_b_in, alu_res_in, res_ready_in,
        input  cmd_ready_out, alu_sel_out, alu_a_out, alu_b_out,
        input  res_valid_out, res_data_out, res_zero_out, res_neg_out, res_ill_out,
        input  op_count_out, busy_out
    );
endinterface

// File: rtl/alu_issue_stage.sv
// Two-stage valid/ready wrapper around an external combinational ALU:
// stage 1 holds the issued command, stage 2 captures the result and its flags.
module alu_issue_stage #(
    parameter int DATA_WIDTH  = 4,
    parameter int COUNT_WIDTH = 8
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    alu_issue_if.slave  bus
);
    localparam int RES_WIDTH = 2 * DATA_WIDTH;

    function automatic logic is_illegal_op(input logic [2:0] op);
        return (op > 3'b101);
    endfunction

    logic                    s1_valid_r;
    logic                    s2_valid_r;
    logic [2:0]              sel_r;
    logic [DATA_WIDTH-1:0]   a_r;
    logic [DATA_WIDTH-1:0]   b_r;
    logic [RES_WIDTH-1:0]    data_r;
    logic                    zero_r;
    logic                    neg_r;
    logic                    ill_r;
    logic [COUNT_WIDTH-1:0]  count_r;

    logic                    s2_free_s;
    logic                    s1_adv_s;
    logic                    ready_s;
    logic                    accept_s;
    logic                    handoff_s;
    logic                    ill_s;
    logic [RES_WIDTH-1:0]    res_s;

    assign s2_free_s = !s2_valid_r || bus.res_ready_in;
    assign s1_adv_s  = s1_valid_r && s2_free_s;
    assign ready_s   = !s1_valid_r || s1_adv_s;
    assign accept_s  = bus.cmd_valid_in && ready_s;
    assign handoff_s = s2_valid_r && bus.res_ready_in;
    assign ill_s     = is_illegal_op(sel_r);
    // Illegal opcodes always yield a zero result regardless of what the ALU returns.
    assign res_s     = ill_s ? {RES_WIDTH{1'b0}} : bus.alu_res_in;

    // Stage 1: command register feeding the ALU; holds steady while stalled.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            s1_valid_r <= 1'b0;
            sel_r      <= 3'b000;
            a_r        <= {DATA_WIDTH{1'b0}};
            b_r        <= {DATA_WIDTH{1'b0}};
        end else if (accept_s) begin
            s1_valid_r <= 1'b1;
            sel_r      <= bus.cmd_op_in;
            a_r        <= bus.cmd_a_in;
            b_r        <= bus.cmd_b_in;
        end else if (s1_adv_s) begin
            s1_valid_r <= 1'b0;
        end
    end

    // Stage 2: result register with status flags for the downstream consumer.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            s2_valid_r <= 1'b0;
            data_r     <= {RES_WIDTH{1'b0}};
            zero_r     <= 1'b0;
            neg_r      <= 1'b0;
            ill_r      <= 1'b0;
        end else if (s1_adv_s) begin
            s2_valid_r <= 1'b1;
            data_r     <= res_s;
            zero_r     <= (res_s == {RES_WIDTH{1'b0}});
            neg_r      <= res_s[RES_WIDTH-1];
            ill_r      <= ill_s;
        end else if (handoff_s) begin
            s2_valid_r <= 1'b0;
        end
    end

    // Completed-operation counter, wraps naturally at its width.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            count_r <= {COUNT_WIDTH{1'b0}};
        end else if (handoff_s) begin
            count_r <= count_r + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign bus.cmd_ready_out = ready_s;
    assign bus.alu_sel_out   = sel_r;
    assign bus.alu_a_out     = a_r;
    assign bus.alu_b_out     = b_r;
    assign bus.res_valid_out = s2_valid_r;
    assign bus.res_data_out  = data_r;
    assign bus.res_zero_out  = zero_r;
    assign bus.res_neg_out   = neg_r;
    assign bus.res_ill_out   = ill_r;
    assign bus.op_count_out  = count_r;
    assign bus.busy_out      = s1_valid_r || s2_valid_r;
endmodule

// File: tb/tb_alu_issue_stage.sv
// Randomised and directed bench for alu_issue_stage with an in-bench ALU and a
// queue-based reference model of the pipeline contents.
module tb_alu_issue_stage;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    alu_issue_if #(.DATA_WIDTH(4), .COUNT_WIDTH(8)) bus ();

    alu_issue_stage #(.DATA_WIDTH(4), .COUNT_WIDTH(8)) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] alu_ref(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        logic signed [7:0] sa;
        logic signed [7:0] sb;
        sa = {{4{a[3]}}, a};
        sb = {{4{b[3]}}, b};
        case (op)
            3'b000:  return sa + sb;
            3'b001:  return sa - sb;
            3'b010:  return sa * sb;
            3'b011:  return sa & sb;
            3'b100:  return sa | sb;
            3'b101:  return sa ^ sb;
            default: return 8'h00;
        endcase
    endfunction

    // External combinational ALU
    always_comb bus.alu_res_in = alu_ref(bus.alu_sel_out, bus.alu_a_out, bus.alu_b_out);

    // Reference: queue of in-flight results {ill, data}; the newest entry is
    // still in the issue register during the cycle right after its accept.
    logic [8:0] q[$];
    bit         last_fresh;
    logic [7:0] exp_count;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit head_visible();
        return (q.size() > 0) && !(q.size() == 1 && last_fresh);
    endfunction

    task automatic drive(input logic v, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b, input logic rr);
        bus.cmd_valid_in = v;
        bus.cmd_op_in    = op;
        bus.cmd_a_in     = a;
        bus.cmd_b_in     = b;
        bus.res_ready_in = rr;
    endtask

    task automatic tick();
        bit         acc;
        bit         hand;
        bit         vis;
        logic [8:0] head;
        acc  = bus.cmd_valid_in && ((q.size() < 2) || bus.res_ready_in);
        hand = head_visible() && bus.res_ready_in;
        @(posedge clk);
        if (hand) begin
            void'(q.pop_front());
            exp_count = exp_count + 8'd1;
        end
        last_fresh = 1'b0;
        if (acc) begin
            q.push_back({(bus.cmd_op_in > 3'b101), alu_ref(bus.cmd_op_in, bus.cmd_a_in, bus.cmd_b_in)});
            last_fresh = 1'b1;
        end
        #1;
        vis = head_visible();
        check_val("cmd_ready", bus.cmd_ready_out, (q.size() < 2) || bus.res_ready_in);
        check_val("res_valid", bus.res_valid_out, vis);
        check_val("busy", bus.busy_out, q.size() > 0);
        check_val("count", bus.op_count_out, exp_count);
        if (vis) begin
            head = q[0];
            check_val("res_data", bus.res_data_out, head[7:0]);
            check_val("res_zero", bus.res_zero_out, head[7:0] == 8'h00);
            check_val("res_neg", bus.res_neg_out, head[7]);
            check_val("res_ill", bus.res_ill_out, head[8]);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b, input logic rr);
        drive(1'b1, op, a, b, rr);
        tick();
        drive(1'b0, 3'b000, 4'h0, 4'h0, rr);
    endtask

    task automatic check_all_clear(input string tag);
        check_val({tag, "_valid"}, bus.res_valid_out, 1'b0);
        check_val({tag, "_busy"}, bus.busy_out, 1'b0);
        check_val({tag, "_data"}, bus.res_data_out, 8'h00);
        check_val({tag, "_flags"}, {bus.res_zero_out, bus.res_neg_out, bus.res_ill_out}, 3'b000);
        check_val({tag, "_count"}, bus.op_count_out, 8'h00);
        check_val({tag, "_alu"}, {bus.alu_sel_out, bus.alu_a_out, bus.alu_b_out}, 11'h000);
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        last_fresh = 1'b0;
        exp_count  = 8'h00;
        rst_n      = 1'b0;
        drive(1'b0, 3'b000, 4'h0, 4'h0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check_all_clear("reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_val("reset_ready", bus.cmd_ready_out, 1'b1);

        // Directed single operations with idle gaps
        issue(3'b000, 4'd3, 4'd2, 1'b1);
        repeat (3) tick();
        check_val("add_count", bus.op_count_out, 8'd1);
        issue(3'b001, 4'b1000, 4'd7, 1'b1);
        repeat (3) tick();
        issue(3'b010, 4'b1000, 4'b1000, 1'b1);
        repeat (3) tick();
        issue(3'b101, 4'd5, 4'd5, 1'b1);
        repeat (3) tick();
        issue(3'b111, 4'd1, 4'd1, 1'b1);
        repeat (3) tick();

        // Back-to-back stream
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 3'(i % 6), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b1);
            tick();
        end
        drive(1'b0, 3'b000, 4'h0, 4'h0, 1'b1);
        repeat (3) tick();

        // Backpressure: two accepts, then stall with a pending command
        issue(3'b000, 4'd1, 4'd6, 1'b0);
        issue(3'b010, 4'd3, 4'b1101, 1'b0);
        drive(1'b1, 3'b100, 4'd9, 4'd2, 1'b0);
        repeat (3) tick();
        drive(1'b0, 3'b000, 4'h0, 4'h0, 1'b1);
        repeat (4) tick();

        // Reset with both stages full
        issue(3'b000, 4'd2, 4'd2, 1'b0);
        issue(3'b001, 4'd2, 4'd5, 1'b0);
        rst_n = 1'b0;
        #1;
        check_all_clear("midreset");
        q.delete();
        last_fresh = 1'b0;
        exp_count  = 8'h00;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) tick();

        // Random traffic, long enough for the counter to wrap
        for (int i = 0; i < 900; i++) begin
            drive(1'($urandom_range(0, 9) < 7), 3'($urandom_range(0, 7)),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 9) < 7));
            tick();
        end
        drive(1'b0, 3'b000, 4'h0, 4'h0, 1'b1);
        repeat (4) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
